// File: rtl/mem_access_pkg.sv
// Shared constants, FSM encoding and access helpers for the memory access stage.
package mem_access_pkg;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Unsigned widths exist only for loads.
  function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return is_load;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return off[0];
      F3_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] access_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: return 4'b0001 << off;
      F3_H, F3_HU: return 4'b0011 << off;
      default:     return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] data);
    case (f3)
      F3_B:    return {4{data[7:0]}};
      F3_H:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword lane of a read word and sign/zero extends it.
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  func3,
  output logic [31:0] data_c
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {byte_off, 3'b000};
    case (func3)
      F3_B:    data_c = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data_c = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data_c = {24'h0, shifted[7:0]};
      F3_HU:   data_c = {16'h0, shifted[15:0]};
      default: data_c = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues data-bus accesses, stalls upstream until completion or
// timeout, and registers the MEM/WB writeback.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        I_Type_Load_MEM,
  input  logic        S_Type_MEM,
  input  logic [31:0] Alu_Out_MEM,
  input  logic [31:0] Address_MEM,
  input  logic [31:0] Store_Data_MEM,
  input  logic [2:0]  Func3_MEM,
  input  logic [4:0]  rd_MEM,
  input  logic        Write_Enable_MEM,
  output logic        Dmem_Req,
  output logic        Dmem_We,
  output logic [31:0] Dmem_Addr,
  output logic [31:0] Dmem_Wdata,
  output logic [3:0]  Dmem_Be,
  input  logic [31:0] Dmem_Rdata,
  input  logic        Dmem_Ack,
  output logic        Stall_MEM,
  output logic [31:0] Result_WB,
  output logic [4:0]  rd_WB,
  output logic        Write_Enable_WB,
  output logic        Misalign_Fault,
  output logic        Bus_Error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d, result_q, result_d;
  logic [3:0]        be_q, be_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d, rd_wb_q, rd_wb_d;
  logic              we_q, we_d, load_q, load_d, wb_we_q, wb_we_d;
  logic              mis_q, mis_d, berr_q, berr_d;
  logic              is_mem, fault, start, done, timeout;
  logic [31:0]       load_data;

  assign is_mem  = I_Type_Load_MEM | S_Type_MEM;
  assign fault   = is_mem & ((I_Type_Load_MEM & S_Type_MEM)
                   | ~f3_legal(I_Type_Load_MEM, Func3_MEM)
                   | misaligned(Func3_MEM, Address_MEM[1:0]));
  assign start   = (state_q == ST_IDLE) & is_mem & ~fault;
  assign done    = (state_q == ST_WAIT) & Dmem_Ack;
  assign timeout = (state_q == ST_WAIT) & ~Dmem_Ack & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  load_align u_load_align (
    .rdata    (Dmem_Rdata),
    .byte_off (off_q),
    .func3    (f3_q),
    .data_c   (load_data)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_WAIT;
      ST_WAIT: if (done || timeout) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, wait counter and MEM/WB writeback selection.
  always_comb begin
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    off_d    = off_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    we_d     = we_q;
    load_d   = load_q;
    result_d = result_q;
    rd_wb_d  = rd_wb_q;
    wb_we_d  = 1'b0;
    mis_d    = 1'b0;
    berr_d   = 1'b0;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
      if (start) begin
        addr_d  = {Address_MEM[31:2], 2'b00};
        off_d   = Address_MEM[1:0];
        wdata_d = S_Type_MEM ? store_wdata(Func3_MEM, Store_Data_MEM) : 32'h0;
        be_d    = access_be(Func3_MEM, Address_MEM[1:0]);
        f3_d    = Func3_MEM;
        rd_d    = rd_MEM;
        we_d    = Write_Enable_MEM;
        load_d  = I_Type_Load_MEM;
      end else if (fault) begin
        mis_d = 1'b1;
      end else if (!is_mem) begin
        result_d = Alu_Out_MEM;
        rd_wb_d  = rd_MEM;
        wb_we_d  = Write_Enable_MEM;
      end
    end else begin
      if (done) begin
        if (load_q) result_d = load_data;
        rd_wb_d = rd_q;
        wb_we_d = load_q & we_q;
      end else if (timeout) begin
        berr_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      off_q    <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
      load_q   <= 1'b0;
      result_q <= '0;
      rd_wb_q  <= '0;
      wb_we_q  <= 1'b0;
      mis_q    <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      off_q    <= off_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      load_q   <= load_d;
      result_q <= result_d;
      rd_wb_q  <= rd_wb_d;
      wb_we_q  <= wb_we_d;
      mis_q    <= mis_d;
      berr_q   <= berr_d;
    end
  end

  // Stall is combinational so upstream advances in the same cycle the ack arrives.
  always_comb begin
    Stall_MEM = ~Reset & (start | ((state_q == ST_WAIT) & is_mem & ~Dmem_Ack & ~timeout));
  end

  assign Dmem_Req        = (state_q == ST_WAIT);
  assign Dmem_We         = (state_q == ST_WAIT) & ~load_q;
  assign Dmem_Addr       = addr_q;
  assign Dmem_Wdata      = wdata_q;
  assign Dmem_Be         = be_q;
  assign Result_WB       = result_q;
  assign rd_WB           = rd_wb_q;
  assign Write_Enable_WB = wb_we_q;
  assign Misalign_Fault  = mis_q;
  assign Bus_Error       = berr_q;

endmodule
